// File: rtl/rst_seq_run_mon_if.sv
// ---------------------------------------------------------------------------
// rst_seq_run_mon_if
// Purpose: bundles the control and status signals of the reset sequencer /
// run monitor so they can be passed around as one port.
// Signals:
//   halt_i        halt request from the CPU side (level)
//   clear_i       soft restart request, honoured only once a run has ended
//   domain_rst_n  per-domain active-low reset, bit 0 released first
//   running       high while the monitored run is in progress
//   done          run ended by a halt request
//   timeout       run ended by the cycle limit
//   cycle_cnt     run cycles elapsed
// Modports:
//   master  the sequencer itself (drives resets and status)
//   slave   the CPU / board / bench side (drives halt and clear)
// ---------------------------------------------------------------------------
interface rst_seq_run_mon_if #(
  parameter int N_DOMAINS = 2,
  parameter int COUNT_W   = 32
);
  logic                 halt_i;
  logic                 clear_i;
  logic [N_DOMAINS-1:0] domain_rst_n;
  logic                 running;
  logic                 done;
  logic                 timeout;
  logic [COUNT_W-1:0]   cycle_cnt;

  // The sequencer consumes the requests and owns every status output.
  modport master (
    input  halt_i, clear_i,
    output domain_rst_n, running, done, timeout, cycle_cnt
  );

  // The controlled side raises requests and observes the sequencer.
  modport slave (
    output halt_i, clear_i,
    input  domain_rst_n, running, done, timeout, cycle_cnt
  );
endinterface

// File: rtl/rst_seq_run_mon.sv
// ---------------------------------------------------------------------------
// rst_seq_run_mon
// Purpose: reset sequencer and run monitor for bare-metal CPU bring-up.
// After rst drops, all domains are held in reset for RST_HOLD cycles, then
// released one by one every STAGE_GAP cycles. Once the last domain is out of
// reset, run cycles are counted until the CPU requests a halt or the count
// reaches RUN_LIMIT (0 = no limit). A clear request in DONE restarts the
// whole sequence.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   rst_seq_run_mon_if.master (halt_i, clear_i in; domain_rst_n,
//         running, done, timeout, cycle_cnt out)
// Optional build macro:
//   RST_SEQ_HALT_SYNC_EN  when defined, halt_i passes through a two-flop
//                         synchronizer so it may come from an asynchronous
//                         source; the halt then lands two cycles later.
// ---------------------------------------------------------------------------
module rst_seq_run_mon #(
  parameter int N_DOMAINS = 2,
  parameter int RST_HOLD  = 4,
  parameter int STAGE_GAP = 2,
  parameter int COUNT_W   = 32,
  parameter int RUN_LIMIT = 40
) (
  input logic clk,
  input logic rst,
  rst_seq_run_mon_if.master bus
);

  localparam int HOLD_W = (RST_HOLD  > 1) ? $clog2(RST_HOLD)  : 1;
  localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IDX_W  = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam logic [COUNT_W-1:0] LIMIT = COUNT_W'(RUN_LIMIT);
  localparam bit LIMIT_EN = (RUN_LIMIT != 0);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN, DONE} state_t;

  state_t               state_q;
  logic [HOLD_W-1:0]    holdCnt_q;
  logic [GAP_W-1:0]     stageCnt_q;
  logic [IDX_W-1:0]     stageIdx_q;
  logic [N_DOMAINS-1:0] domRstN_q;
  logic                 running_q;
  logic                 done_q;
  logic                 timeout_q;
  logic [COUNT_W-1:0]   cycleCnt_q;
  logic [COUNT_W-1:0]   cycleInc_d;
  logic                 haltEff;

`ifdef RST_SEQ_HALT_SYNC_EN
  logic haltMeta_q;
  logic haltSync_q;

  // Two-stage synchronizer so a board button or other asynchronous source
  // can drive halt_i; the FSM only ever looks at the second stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      haltMeta_q <= 1'b0;
      haltSync_q <= 1'b0;
    end else begin
      haltMeta_q <= bus.halt_i;
      haltSync_q <= haltMeta_q;
    end
  end

  assign haltEff = haltSync_q;
`else
  assign haltEff = bus.halt_i;
`endif

  // Candidate next run count; sticks at all-ones instead of wrapping so a
  // long unlimited run never looks like a fresh one.
  always_comb begin
    cycleInc_d = cycleCnt_q;
    if (cycleCnt_q != '1) begin
      cycleInc_d = cycleCnt_q + COUNT_W'(1);
    end
  end

  // Main sequencer. HOLD counts the initial hold time and frees domain 0,
  // RELEASE frees one further domain every STAGE_GAP cycles, RUN counts
  // cycles until a halt (which takes priority) or the limit, and DONE
  // freezes the result until a clear request restarts from HOLD. All
  // outputs are registered here so nothing combinational reaches a pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HOLD;
      holdCnt_q  <= '0;
      stageCnt_q <= '0;
      stageIdx_q <= '0;
      domRstN_q  <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cycleCnt_q <= '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (holdCnt_q == HOLD_W'(RST_HOLD - 1)) begin
            domRstN_q[0] <= 1'b1;
            holdCnt_q    <= '0;
            stageCnt_q   <= '0;
            stageIdx_q   <= IDX_W'(1);
            if (N_DOMAINS == 1) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            holdCnt_q <= holdCnt_q + HOLD_W'(1);
          end
        end
        RELEASE: begin
          if (stageCnt_q == GAP_W'(STAGE_GAP - 1)) begin
            stageCnt_q <= '0;
            for (int i = 0; i < N_DOMAINS; i++) begin
              if (stageIdx_q == IDX_W'(i)) begin
                domRstN_q[i] <= 1'b1;
              end
            end
            stageIdx_q <= stageIdx_q + IDX_W'(1);
            if (stageIdx_q == IDX_W'(N_DOMAINS - 1)) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end else begin
            stageCnt_q <= stageCnt_q + GAP_W'(1);
          end
        end
        RUN: begin
          if (haltEff) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            cycleCnt_q <= cycleInc_d;
            if (LIMIT_EN && (cycleInc_d == LIMIT)) begin
              state_q   <= DONE;
              running_q <= 1'b0;
              timeout_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.clear_i) begin
            state_q    <= HOLD;
            holdCnt_q  <= '0;
            stageCnt_q <= '0;
            stageIdx_q <= '0;
            domRstN_q  <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cycleCnt_q <= '0;
          end
        end
        default: begin
          state_q <= HOLD;
        end
      endcase
    end
  end

  assign bus.domain_rst_n = domRstN_q;
  assign bus.running      = running_q;
  assign bus.done         = done_q;
  assign bus.timeout      = timeout_q;
  assign bus.cycle_cnt    = cycleCnt_q;

endmodule

// File: tb/tb_rst_seq_run_mon.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_run_mon
// Three sequencer instances share clk/rst: A uses the default parameters,
// B has RUN_LIMIT = 5, C has N_DOMAINS = 3, COUNT_W = 4 and no limit.
// Stimulus pushes hand-computed expectations (tagged with the clock tick at
// which they must hold) into a scoreboard queue; an independent monitor pops
// and compares them shortly after each falling edge.
// ---------------------------------------------------------------------------
module tb_rst_seq_run_mon;

`ifdef RST_SEQ_HALT_SYNC_EN
  localparam int HL = 2;
`else
  localparam int HL = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tick = 0;

  typedef struct {
    int         at;
    int         dut;
    int         tag;
    logic [7:0] dom;
    logic       run;
    logic       dn;
    logic       to;
    logic [31:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   passCnt = 0;
  int   totalCnt = 0;
  int   tagNext = 0;

  exp_t        e;
  logic [7:0]  aDom;
  logic        aRun;
  logic        aDn;
  logic        aTo;
  logic [31:0] aCnt;

  rst_seq_run_mon_if #(.N_DOMAINS(2), .COUNT_W(32)) busA ();
  rst_seq_run_mon_if #(.N_DOMAINS(2), .COUNT_W(32)) busB ();
  rst_seq_run_mon_if #(.N_DOMAINS(3), .COUNT_W(4))  busC ();

  rst_seq_run_mon #(.N_DOMAINS(2), .RST_HOLD(4), .STAGE_GAP(2), .COUNT_W(32), .RUN_LIMIT(40))
    dutA (.clk(clk), .rst(rst), .bus(busA));
  rst_seq_run_mon #(.N_DOMAINS(2), .RST_HOLD(4), .STAGE_GAP(2), .COUNT_W(32), .RUN_LIMIT(5))
    dutB (.clk(clk), .rst(rst), .bus(busB));
  rst_seq_run_mon #(.N_DOMAINS(3), .RST_HOLD(4), .STAGE_GAP(2), .COUNT_W(4), .RUN_LIMIT(0))
    dutC (.clk(clk), .rst(rst), .bus(busC));

  // Free-running clock and a tick counter of rising edges.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick <= tick + 1;
  end

  // Hard stop in case something wedges the stimulus.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: shortly after every falling edge, compare every expectation
  // whose tick has come against the matching instance's outputs.
  always @(negedge clk) begin
    #2;
    while (sbq.size() > 0 && sbq[0].at <= tick) begin
      e = sbq.pop_front();
      case (e.dut)
        0: begin
          aDom = 8'(busA.domain_rst_n);
          aRun = busA.running;
          aDn  = busA.done;
          aTo  = busA.timeout;
          aCnt = 32'(busA.cycle_cnt);
        end
        1: begin
          aDom = 8'(busB.domain_rst_n);
          aRun = busB.running;
          aDn  = busB.done;
          aTo  = busB.timeout;
          aCnt = 32'(busB.cycle_cnt);
        end
        default: begin
          aDom = 8'(busC.domain_rst_n);
          aRun = busC.running;
          aDn  = busC.done;
          aTo  = busC.timeout;
          aCnt = 32'(busC.cycle_cnt);
        end
      endcase
      totalCnt++;
      if (aDom === e.dom && aRun === e.run && aDn === e.dn && aTo === e.to && aCnt === e.cnt) begin
        passCnt++;
      end else begin
        $display("[TB] FAIL chk%0d dut%0d tick%0d: got dom=%b run=%b done=%b to=%b cnt=%0d, want dom=%b run=%b done=%b to=%b cnt=%0d",
                 e.tag, e.dut, tick, aDom, aRun, aDn, aTo, aCnt, e.dom, e.run, e.dn, e.to, e.cnt);
      end
    end
  end

  // Queue an expectation for one instance at a given tick.
  task automatic checkOutput(input int at, input int dut, input logic [7:0] dom,
                             input logic run, input logic dn, input logic to,
                             input logic [31:0] cnt);
    exp_t x;
    x.at  = at;
    x.dut = dut;
    x.tag = tagNext;
    x.dom = dom;
    x.run = run;
    x.dn  = dn;
    x.to  = to;
    x.cnt = cnt;
    tagNext++;
    sbq.push_back(x);
  endtask

  // Drive halt/clear of one instance.
  task automatic applyStimulus(input int dut, input logic halt, input logic clear);
    case (dut)
      0: begin busA.halt_i = halt; busA.clear_i = clear; end
      1: begin busB.halt_i = halt; busB.clear_i = clear; end
      default: begin busC.halt_i = halt; busC.clear_i = clear; end
    endcase
  endtask

  task automatic waitTick(input int t);
    while (tick < t) @(negedge clk);
  endtask

  // One-cycle request pulse, raised at the falling edge of tick 'at' so the
  // following rising edge samples it.
  task automatic pulseReq(input int dut, input int at, input logic halt, input logic clear);
    waitTick(at);
    applyStimulus(dut, halt, clear);
    @(negedge clk);
    applyStimulus(dut, 1'b0, 1'b0);
  endtask

  task automatic assertReset();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) checkOutput(tick + 1, d, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic releaseReset(output int base);
    @(negedge clk);
    rst  = 1'b0;
    base = tick;
  endtask

  initial begin
    int b;
    int b2;
    for (int d = 0; d < 3; d++) applyStimulus(d, 1'b0, 1'b0);

    // Default run to timeout; clear during RUN is ignored; B hits its limit.
    assertReset();
    releaseReset(b);
    checkOutput(b + 3,  0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput(b + 4,  0, 8'h01, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput(b + 5,  0, 8'h01, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput(b + 6,  0, 8'h03, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput(b + 7,  0, 8'h03, 1'b1, 1'b0, 1'b0, 32'd1);
    checkOutput(b + 10, 1, 8'h03, 1'b1, 1'b0, 1'b0, 32'd4);
    checkOutput(b + 11, 1, 8'h03, 1'b0, 1'b0, 1'b1, 32'd5);
    checkOutput(b + 21, 0, 8'h03, 1'b1, 1'b0, 1'b0, 32'd15);
    checkOutput(b + 45, 0, 8'h03, 1'b1, 1'b0, 1'b0, 32'd39);
    checkOutput(b + 46, 0, 8'h03, 1'b0, 1'b0, 1'b1, 32'd40);
    checkOutput(b + 50, 0, 8'h03, 1'b0, 1'b0, 1'b1, 32'd40);
    pulseReq(0, b + 19, 1'b0, 1'b1);
    waitTick(b + 50);

    // Halt on A at cnt 10; halt on B coinciding with its limit edge.
    assertReset();
    releaseReset(b);
    checkOutput(b + 10,      1, 8'h03, 1'b1, 1'b0, 1'b0, 32'd4);
    checkOutput(b + 11,      1, 8'h03, 1'b0, 1'b1, 1'b0, 32'd4);
    checkOutput(b + 15,      1, 8'h03, 1'b0, 1'b1, 1'b0, 32'd4);
    checkOutput(b + 16,      0, 8'h03, 1'b1, 1'b0, 1'b0, 32'd10);
    checkOutput(b + 17 + HL, 0, 8'h03, 1'b0, 1'b1, 1'b0, 32'(10 + HL));
    checkOutput(b + 37 + HL, 0, 8'h03, 1'b0, 1'b1, 1'b0, 32'(10 + HL));
    pulseReq(1, b + 10 - HL, 1'b1, 1'b0);
    pulseReq(0, b + 16, 1'b1, 1'b0);
    waitTick(b + 37 + HL);

    // Reset mid-RELEASE, then an identical replay with halt ignored in HOLD.
    assertReset();
    releaseReset(b);
    checkOutput(b + 4, 0, 8'h01, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput(b + 5, 0, 8'h01, 1'b0, 1'b0, 1'b0, 32'd0);
    pulseReq(0, b + 1, 1'b1, 1'b0);
    waitTick(b + 5);
    #4;
    rst = 1'b1;
    checkOutput(tick + 1, 0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    releaseReset(b);
    checkOutput(b + 3,  0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput(b + 4,  0, 8'h01, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput(b + 6,  0, 8'h03, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput(b + 7,  0, 8'h03, 1'b1, 1'b0, 1'b0, 32'd1);
    checkOutput(b + 46, 0, 8'h03, 1'b0, 1'b0, 1'b1, 32'd40);
    checkOutput(b + 50, 0, 8'h03, 1'b0, 1'b0, 1'b1, 32'd40);
    pulseReq(0, b + 1, 1'b1, 1'b0);

    // Clear from DONE restarts the staged release and a second timed run.
    checkOutput(b + 51, 0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
    b2 = b + 51;
    checkOutput(b2 + 3,  0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput(b2 + 4,  0, 8'h01, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput(b2 + 6,  0, 8'h03, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput(b2 + 46, 0, 8'h03, 1'b0, 1'b0, 1'b1, 32'd40);
    pulseReq(0, b + 50, 1'b0, 1'b1);
    waitTick(b2 + 47);

    // Three domains, 4-bit counter, no limit: saturation at 15.
    assertReset();
    releaseReset(b);
    checkOutput(b + 6,  2, 8'h03, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput(b + 7,  2, 8'h03, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput(b + 8,  2, 8'h07, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput(b + 9,  2, 8'h07, 1'b1, 1'b0, 1'b0, 32'd1);
    checkOutput(b + 22, 2, 8'h07, 1'b1, 1'b0, 1'b0, 32'd14);
    checkOutput(b + 23, 2, 8'h07, 1'b1, 1'b0, 1'b0, 32'd15);
    checkOutput(b + 40, 2, 8'h07, 1'b1, 1'b0, 1'b0, 32'd15);
    waitTick(b + 40);

    // Halt on C at cnt 3.
    assertReset();
    releaseReset(b);
    checkOutput(b + 11,      2, 8'h07, 1'b1, 1'b0, 1'b0, 32'd3);
    checkOutput(b + 12 + HL, 2, 8'h07, 1'b0, 1'b1, 1'b0, 32'(3 + HL));
    checkOutput(b + 20,      2, 8'h07, 1'b0, 1'b1, 1'b0, 32'(3 + HL));
    pulseReq(2, b + 11, 1'b1, 1'b0);
    waitTick(b + 21);

    // Every queued expectation must have been consumed by the monitor.
    waitTick(tick + 2);
    totalCnt++;
    if (sbq.size() == 0) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL scoreboard_drain: pending=%0d required=0", sbq.size());
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
